// File: rtl/apb_slave_if.sv
// rtl/apb_slave_if.sv - APB bus bundle between one master and one completer.
interface apb_slave_if #(
  parameter int WIDTH = 8
);
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [WIDTH-1:0] paddr;
  logic [WIDTH-1:0] pwdata;
  logic [WIDTH-1:0] prdata;
  logic             pready;
  logic             pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB completer with a DEPTH-word register file and fixed wait states.
module apb_slave #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          pclk,
  input  logic          presetn,
  apb_slave_if.slave    bus
);
  localparam int               AW      = $clog2(DEPTH);
  localparam logic [3:0]       WAIT_C  = 4'(WAIT_CYCLES);
  localparam logic [WIDTH:0]   DEPTH_C = (WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] prdata_q, prdata_d;
  logic             mem_we;
  logic             ready;
  logic             setup_err;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // pready comes from registered state only, so the master sees no input-to-output path
  assign ready       = (state_q == S_ACCESS) && (cnt_q == WAIT_C);
  assign setup_err   = ({1'b0, bus.paddr} >= DEPTH_C);
  assign bus.pready  = ready;
  assign bus.pslverr = ready & err_q;
  assign bus.prdata  = prdata_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.psel && !bus.penable) begin
          addr_d  = bus.paddr[AW-1:0];
          wdata_d = bus.pwdata;
          write_d = bus.pwrite;
          err_d   = setup_err;
          cnt_d   = 4'd0;
          state_d = S_ACCESS;
          if (!bus.pwrite) begin
            prdata_d = setup_err ? '0 : mem_q[bus.paddr[AW-1:0]];
          end
        end
      end
      S_ACCESS: begin
        if (!bus.psel) begin
          state_d = S_IDLE;
        end else if (bus.penable) begin
          if (ready) begin
            mem_we  = write_q && !err_q;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
      if (mem_we) begin
        mem_q[addr_q] <= wdata_q;
      end
    end
  end
endmodule

// File: tb/tb_apb_slave.sv
// tb/tb_apb_slave.sv - Directed bench for apb_slave at two wait-state settings.
module tb_apb_slave;
  logic pclk;
  logic presetn;

  apb_slave_if #(.WIDTH(8)) bus2 ();
  apb_slave_if #(.WIDTH(8)) bus0 ();

  apb_slave #(.WIDTH(8), .DEPTH(16), .WAIT_CYCLES(2)) dut2 (
    .pclk(pclk), .presetn(presetn), .bus(bus2.slave)
  );
  apb_slave #(.WIDTH(8), .DEPTH(16), .WAIT_CYCLES(0)) dut0 (
    .pclk(pclk), .presetn(presetn), .bus(bus0.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model per DUT: index 1 is the 2-wait device, index 0 the zero-wait device
  logic [7:0] mmem [2][16];
  logic [7:0] mprd [2];
  logic       eready [2];
  logic       eerr [2];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic get_ready(input int d);
    return (d == 1) ? bus2.pready : bus0.pready;
  endfunction

  function automatic logic [7:0] get_prdata(input int d);
    return (d == 1) ? bus2.prdata : bus0.prdata;
  endfunction

  always @(negedge pclk) begin
    if (chk_en) begin
      chk("w2_pready",  {7'd0, bus2.pready},  {7'd0, eready[1]});
      chk("w2_pslverr", {7'd0, bus2.pslverr}, {7'd0, eerr[1]});
      chk("w2_prdata",  bus2.prdata,          mprd[1]);
      chk("w0_pready",  {7'd0, bus0.pready},  {7'd0, eready[0]});
      chk("w0_pslverr", {7'd0, bus0.pslverr}, {7'd0, eerr[0]});
      chk("w0_prdata",  bus0.prdata,          mprd[0]);
    end
  end

  task automatic drive(input int d, input logic s, input logic e, input logic w,
                       input logic [7:0] a, input logic [7:0] wd);
    if (d == 1) begin
      bus2.psel = s; bus2.penable = e; bus2.pwrite = w; bus2.paddr = a; bus2.pwdata = wd;
    end else begin
      bus0.psel = s; bus0.penable = e; bus0.pwrite = w; bus0.paddr = a; bus0.pwdata = wd;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) mmem[d][i] = 8'h00;
      mprd[d] = 8'h00; eready[d] = 1'b0; eerr[d] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    eready[0] = 1'b0; eerr[0] = 1'b0; eready[1] = 1'b0; eerr[1] = 1'b0;
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  // One transfer; lat = ACCESS cycle number (1-based) in which pready was first seen
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      input bit abort, output logic [7:0] rd, output int lat);
    int  w   = (d == 1) ? 2 : 0;
    bit  bad = (a >= 8'd16);
    rd = 8'h00; lat = 0;
    drive(d, 1'b1, 1'b0, wr, a, wd);
    eready[d] = 1'b0; eerr[d] = 1'b0;
    @(posedge pclk); #1;
    if (!wr) mprd[d] = bad ? 8'h00 : mmem[d][a[3:0]];
    if (abort) begin
      drive(d, 1'b0, 1'b0, wr, 8'h00, 8'h00);
      @(negedge pclk);
      if (get_ready(d)) lat = 1;
      @(posedge pclk); #1;
      return;
    end
    for (int k = 0; k <= w; k++) begin
      // Scrambled address/data/direction during ACCESS must be ignored
      drive(d, 1'b1, 1'b1, !wr, ~a, ~wd);
      eready[d] = (k == w);
      eerr[d]   = (k == w) && bad;
      @(negedge pclk);
      if (get_ready(d) && lat == 0) begin
        lat = k + 1;
        rd  = get_prdata(d);
      end
      @(posedge pclk); #1;
    end
    if (wr && !bad) mmem[d][a[3:0]] = wd;
    eready[d] = 1'b0; eerr[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rd;
    int lat;
    presetn = 1'b0;
    model_reset();
    idle(0);
    chk_en = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_pready",  {7'd0, bus2.pready},  8'h00);
    chk("reset_pslverr", {7'd0, bus2.pslverr}, 8'h00);
    chk("reset_prdata",  bus2.prdata,          8'h00);
    presetn = 1'b1;
    idle(1);

    // 1: write with two wait states
    xfer(1, 1'b1, 8'd3, 8'hA5, 1'b0, rd, lat);
    chk("t1_latency", 8'(lat), 8'd3);
    idle(1);

    // 2: read-back and never-written word
    xfer(1, 1'b0, 8'd3, 8'h00, 1'b0, rd, lat);
    chk("t2_read3", rd, 8'hA5);
    chk("t2_latency", 8'(lat), 8'd3);
    xfer(1, 1'b0, 8'd7, 8'h00, 1'b0, rd, lat);
    chk("t2_read7", rd, 8'h00);

    // 3: out-of-range write and read; prdata primed nonzero first
    xfer(1, 1'b1, 8'd20, 8'h55, 1'b0, rd, lat);
    chk("t3_wr_latency", 8'(lat), 8'd3);
    xfer(1, 1'b0, 8'd3, 8'h00, 1'b0, rd, lat);
    xfer(1, 1'b0, 8'd20, 8'h00, 1'b0, rd, lat);
    chk("t3_rd_err_data", rd, 8'h00);
    for (int i = 0; i < 16; i++) begin
      xfer(1, 1'b0, 8'(i), 8'h00, 1'b0, rd, lat);
      chk($sformatf("t3_readback_%0d", i), rd, (i == 3) ? 8'hA5 : 8'h00);
    end
    idle(1);

    // 5: abort in the first ACCESS cycle, then prove IDLE by a normal read
    xfer(1, 1'b1, 8'd5, 8'hFF, 1'b1, rd, lat);
    chk("t5_no_ready", 8'(lat), 8'd0);
    idle(2);
    xfer(1, 1'b0, 8'd5, 8'h00, 1'b0, rd, lat);
    chk("t5_mem5", rd, 8'h00);
    xfer(1, 1'b0, 8'd3, 8'h00, 1'b0, rd, lat);
    chk("t5_idle_read", rd, 8'hA5);

    // 6: reset during the second wait state of a write
    drive(1, 1'b1, 1'b0, 1'b1, 8'd4, 8'h44);
    @(posedge pclk); #1;
    drive(1, 1'b1, 1'b1, 1'b1, 8'd4, 8'h44);
    @(posedge pclk); #1;
    #2;
    presetn = 1'b0;
    model_reset();
    #1;
    chk("t6_async_pready",  {7'd0, bus2.pready},  8'h00);
    chk("t6_async_pslverr", {7'd0, bus2.pslverr}, 8'h00);
    chk("t6_async_prdata",  bus2.prdata,          8'h00);
    idle(0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    idle(1);
    xfer(1, 1'b0, 8'd4, 8'h00, 1'b0, rd, lat);
    chk("t6_mem4", rd, 8'h00);
    xfer(1, 1'b1, 8'd9, 8'h99, 1'b0, rd, lat);
    chk("t6_after_latency", 8'(lat), 8'd3);
    xfer(1, 1'b0, 8'd9, 8'h00, 1'b0, rd, lat);
    chk("t6_after_read", rd, 8'h99);
    idle(1);

    // 4: zero wait states, back-to-back
    xfer(0, 1'b1, 8'd1, 8'h11, 1'b0, rd, lat);
    chk("t4_lat_w1", 8'(lat), 8'd1);
    xfer(0, 1'b1, 8'd2, 8'h22, 1'b0, rd, lat);
    chk("t4_lat_w2", 8'(lat), 8'd1);
    xfer(0, 1'b0, 8'd1, 8'h00, 1'b0, rd, lat);
    chk("t4_lat_r1", 8'(lat), 8'd1);
    chk("t4_read1", rd, 8'h11);
    xfer(0, 1'b0, 8'd2, 8'h00, 1'b0, rd, lat);
    chk("t4_read2", rd, 8'h22);
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
